// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the fully-connected layer stream loader.
// Default sizes describe the 84-input layer with 48 non-zero weights.
package fc_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam int FC_WIDTH      = 8;
    localparam int FC_IN         = 84;
    localparam int FC_NZ_WEIGHTS = 48;

    // Settle counter holds SETTLE_CYC-1, and SETTLE_CYC is at most 15.
    localparam int CNT_W = 4;

    // Full-precision adder-tree result width: product width plus growth.
    function automatic int fc_out_width(input int width, input int n_prod);
        return 2 * width + $clog2(n_prod);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FC_OUT_WIDTH = fc_out_width(FC_WIDTH, FC_NZ_WEIGHTS);
    localparam int FC_IDX_W     = idx_width(FC_IN);

endpackage

// File: rtl/fc_stream_loader.sv
// Streams activation elements into a parallel vector for a combinational FC layer,
// waits for the adder tree to settle, then returns the captured result on valid/ready.
//
// state  | meaning
// LOAD   | accepting elements, writing x_vec[idx]
// SETTLE | x_vec frozen, counting down until z_in is stable
// OUTPUT | result held on m_data until downstream takes it
module fc_stream_loader
    import fc_pkg::*;
#(
    parameter int WIDTH      = FC_WIDTH,
    parameter int IN         = FC_IN,
    parameter int OUT_WIDTH  = FC_OUT_WIDTH,
    parameter int SETTLE_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WIDTH-1:0]          s_data,
    input  logic                      s_last,
    output logic [IN-1:0][WIDTH-1:0]  x_vec,
    input  logic [OUT_WIDTH-1:0]      z_in,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [OUT_WIDTH-1:0]      m_data,
    output logic                      err_short,
    output logic                      err_long
);

    localparam int               IDX_W       = idx_width(IN);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(IN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_settle;
    logic                   r_m_valid;
    logic [OUT_WIDTH-1:0]   r_m_data;
    logic                   r_err_short;
    logic                   r_err_long;
    logic [WIDTH-1:0]       r_x [IN];

    logic                   w_in_load;
    logic                   w_beat;
    logic                   w_at_end;
    logic                   w_frame_done;
    logic                   w_capture;
    logic                   w_release;

    assign w_in_load    = (r_state == LOAD);
    assign w_beat       = s_valid & w_in_load;
    assign w_at_end     = (r_idx == LAST_IDX);
    assign w_frame_done = w_beat & (s_last | w_at_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_frame_done) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (r_m_valid && m_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_settle    <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            // Both flags describe the terminating beat only, so they are exclusive.
            r_err_short <= w_frame_done & s_last & ~w_at_end;
            r_err_long  <= w_beat & w_at_end & ~s_last;

            if (w_beat) begin
                r_idx <= w_frame_done ? '0 : r_idx + 1'b1;
            end

            if (w_frame_done) begin
                r_settle <= SETTLE_LOAD;
            end else if ((r_state == SETTLE) && (r_settle != '0)) begin
                r_settle <= r_settle - 1'b1;
            end

            if (w_capture) begin
                r_m_data  <= z_in;
                r_m_valid <= 1'b1;
            end else if (w_release) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    // Clearing on release gives short frames their zero padding.
    for (genvar k = 0; k < IN; k++) begin : g_elem
        always_ff @(posedge clk) begin
            if (!rst_n || w_release) begin
                r_x[k] <= '0;
            end else if (w_beat && (r_idx == IDX_W'(k))) begin
                r_x[k] <= s_data;
            end
        end
        assign x_vec[k] = r_x[k];
    end

    assign s_ready   = w_in_load;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign err_short = r_err_short;
    assign err_long  = r_err_long;

endmodule

// File: tb/tb_fc_stream_loader.sv
// Scoreboard bench for fc_stream_loader: the driver predicts each frame's vector,
// result, error flag and timing; an independent monitor checks what the DUT presents.
module tb_fc_stream_loader;

    localparam int WIDTH = 8;
    localparam int IN    = 84;
    localparam int OW    = 22;
    localparam int SC    = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     s_valid;
    logic                     s_ready;
    logic [WIDTH-1:0]         s_data;
    logic                     s_last;
    logic [IN-1:0][WIDTH-1:0] x_vec;
    logic [OW-1:0]            z_in;
    logic                     m_valid;
    logic                     m_ready;
    logic [OW-1:0]            m_data;
    logic                     err_short;
    logic                     err_long;

    fc_stream_loader #(
        .WIDTH(WIDTH), .IN(IN), .OUT_WIDTH(OW), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .x_vec(x_vec), .z_in(z_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_short(err_short), .err_long(err_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int stall_req = 0;
    bit rnd_mode = 1'b0;

    // err: 0 none, 1 short, 2 long; t is the cycle the terminating beat was presented
    typedef struct {
        logic [IN-1:0][WIDTH-1:0] x;
        logic [OW-1:0]            z;
        int                       err;
        longint                   t;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_x(input string name, input logic [IN-1:0][WIDTH-1:0] act,
                           input logic [IN-1:0][WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            int k;
            k = 0;
            while (k < IN - 1 && act[k] === exp[k]) k++;
            n_err++;
            $display("FAIL %s: x_vec[%0d] got %0h expected %0h at cycle %0d",
                     name, k, act[k], exp[k], cyc);
        end
    endtask

    // Downstream: either always ready or random, with an optional stall burst on a result.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req > 0 && m_valid) begin
                m_ready = 1'b0;
                stall_req--;
            end else begin
                m_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        bit            prev_mv;
        bit            prev_stall;
        bit            prev_hs;
        logic [OW-1:0] prev_md;
        int            ns;
        int            nl;
        longint        ecyc;
        exp_t          e;
        prev_mv = 0; prev_stall = 0; prev_hs = 0; prev_md = '0; ns = 0; nl = 0; ecyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_mv = 0; prev_stall = 0; prev_hs = 0; ns = 0; nl = 0;
                continue;
            end
            if (err_short === 1'b1) begin ns++; ecyc = cyc; end
            if (err_long === 1'b1) begin nl++; ecyc = cyc; end
            if (prev_stall) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_data", 64'(m_data), 64'(prev_md));
            end
            if (prev_hs) begin
                check_x("clear_after_accept", x_vec, '0);
                check("ready_after_accept", 64'(s_ready), 64'(1));
            end
            if (m_valid) check("s_ready_low_in_output", 64'(s_ready), 64'(0));
            if (m_valid && !prev_mv) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: m_data %0h with nothing expected", m_data);
                end else begin
                    e = q.pop_front();
                    check("m_data", 64'(m_data), 64'(e.z));
                    check_x("x_vec", x_vec, e.x);
                    check("latency", 64'(cyc), 64'(e.t + 1 + SC));
                    check("err_short_count", 64'(ns), 64'(e.err == 1));
                    check("err_long_count", 64'(nl), 64'(e.err == 2));
                    if (e.err != 0) check("err_pulse_cycle", 64'(ecyc), 64'(e.t + 1));
                end
                ns = 0;
                nl = 0;
            end
            prev_stall = m_valid && !m_ready;
            prev_hs    = m_valid && m_ready;
            prev_mv    = m_valid;
            prev_md    = m_data;
        end
    end

    // Enters and leaves just after a rising edge.
    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_x("reset_x_vec", x_vec, '0);
        check("reset_m_valid", 64'(m_valid), 64'(0));
        check("reset_m_data", 64'(m_data), 64'(0));
        check("reset_err_short", 64'(err_short), 64'(0));
        check("reset_err_long", 64'(err_long), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(s_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    // Sends n elements (n <= IN); with last_end the final one carries s_last.
    // abort_at > 0 resets the DUT right after that many beats were accepted.
    task automatic send_frame(input int n, input bit last_end, input int gap_pct,
                              input bit seq, input logic [OW-1:0] z, input int abort_at);
        exp_t   e;
        longint t;
        e.x = '0;
        t   = 0;
        for (int i = 0; i < n; i++) begin
            logic [WIDTH-1:0] d;
            bit               done;
            int               guard;
            d     = seq ? WIDTH'(i + 1) : WIDTH'($urandom);
            done  = 0;
            guard = 0;
            while (!done) begin
                s_valid = ($urandom_range(0, 99) >= gap_pct);
                s_data  = d;
                s_last  = last_end && (i == n - 1);
                @(negedge clk);
                if (s_valid && s_ready) begin
                    done = 1;
                    t    = cyc;
                end
                @(posedge clk);
                #1;
                guard++;
                if (!done && guard > 500) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL beat_timeout: element %0d never accepted, s_ready %0b", i, s_ready);
                    s_valid = 1'b0;
                    return;
                end
            end
            e.x[i] = d;
            if (abort_at == i + 1) begin
                do_reset();
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = WIDTH'($urandom);
        z_in    = z;
        e.z     = z;
        e.t     = t;
        if (last_end && n < IN)       e.err = 1;
        else if (!last_end && n == IN) e.err = 2;
        else                           e.err = 0;
        q.push_back(e);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        z_in    = '0;
        @(posedge clk);
        #1;
        do_reset();

        send_frame(IN, 1, 0, 1, 22'h00ABCD, 0);
        stall_req = 10;
        send_frame(IN, 1, 0, 1, 22'h00ABCD, 0);
        send_frame(5, 1, 0, 0, OW'($urandom), 0);
        send_frame(1, 1, 0, 0, OW'($urandom), 0);
        send_frame(IN, 0, 0, 0, OW'($urandom), 0);
        send_frame(IN, 1, 50, 0, OW'($urandom), 0);
        send_frame(IN, 1, 0, 0, OW'($urandom), 40);
        send_frame(IN, 1, 0, 1, 22'h3F0F0F, 0);

        rnd_mode = 1'b1;
        for (int f = 0; f < 12; f++) begin
            int n;
            bit l;
            n = $urandom_range(1, IN);
            l = (n < IN) ? 1'b1 : 1'($urandom_range(0, 1));
            send_frame(n, l, $urandom_range(0, 60), 0, OW'($urandom), 0);
        end

        begin
            int guard;
            guard = 0;
            while ((q.size() != 0 || m_valid) && guard < 3000) begin
                @(posedge clk);
                guard++;
            end
            if (guard >= 3000) begin
                n_vec++;
                n_err++;
                $display("FAIL drain_timeout: %0d results still pending", q.size());
            end
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
